// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM state type, GF(2^8)/S-box helpers and FIPS-197 vectors.
package aes_pkg;
   localparam int AES_NR = 10;
   localparam int AES_BLOCK_W = 128;
   localparam int AES_KEY_W = 128;
   localparam int AES_SCHED_W = AES_BLOCK_W * (AES_NR + 1);

   typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} aesState_t;

   localparam logic [127:0] FIPS_B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] FIPS_B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FIPS_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_C1_PT  = 128'h00112233445566778899aabbccddeeff;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h00;
      p = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ p;
         p = xtime(p);
      end
      return r;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
      return (a << n) | (a >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = gfInv(a);
      return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] invSbox(input logic [7:0] a);
      return gfInv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [AES_BLOCK_W-1:0] rk(input logic [AES_SCHED_W-1:0] full, input logic [3:0] r);
      logic [10:0] base;
      base = {r, 7'd0};
      return full[base +: AES_BLOCK_W];
   endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; InvMixColumns is skipped when last is set.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] state,
   input  logic [AES_BLOCK_W-1:0] round_key,
   input  logic                   last,
   output logic [AES_BLOCK_W-1:0] result
);
   // Byte i sits at bits [127-8*i -: 8]; row = i%4, column = i/4
   function automatic logic [127:0] invShiftRows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[127-8*((i % 4) + 4*(((i / 4) - (i % 4) + 4) % 4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] invSubBytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = invSbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] invMixColumns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
         o[119-32*c -: 8] = gmul(a0, 8'd9) ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
         o[111-32*c -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9) ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
         o[103-32*c -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9) ^ gmul(a3, 8'd14);
      end
      return o;
   endfunction

   logic [AES_BLOCK_W-1:0] added;

   assign added = invSubBytes(invShiftRows(state)) ^ round_key;
   assign result = last ? added : invMixColumns(added);
endmodule

// File: rtl/aes_key_expansion.sv
// KeyExpansion: combinational AES-128 key schedule; round key r occupies bits [r*128+127 -: 128].
module KeyExpansion
   import aes_pkg::*;
(
   input  logic [AES_KEY_W-1:0]   key,
   output logic [AES_SCHED_W-1:0] roundKeys
);
   function automatic logic [AES_SCHED_W-1:0] expand(input logic [AES_KEY_W-1:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0] rc;
      logic [AES_SCHED_W-1:0] full;
      rc = 8'h01;
      full = '0;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= AES_NR; r++) full[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return full;
   endfunction

   assign roundKeys = expand(key);
endmodule

// File: rtl/aes128_inv_cipher.sv
// aes128_inv_cipher: iterative AES-128 decryption, one round per clock, valid/ready on both sides.
module aes128_inv_cipher
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] ciphertext,
   input  logic [AES_KEY_W-1:0]   key,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] plaintext,
   output logic                   busy
);
   aesState_t fsm, fsmNext;
   logic [3:0] rnd_q;
   logic [AES_BLOCK_W-1:0] ct_q, state_q, roundKey, roundOut;
   logic [AES_KEY_W-1:0] key_q;
   logic [AES_SCHED_W-1:0] roundKeys;

   KeyExpansion keyExp (.key(key_q), .roundKeys(roundKeys));

   // FINAL always needs rk0; rnd_q parks at 1 there
   assign roundKey = rk(roundKeys, fsm == FINAL ? 4'd0 : rnd_q);

   aes_inv_round invRound (.state(state_q), .round_key(roundKey), .last(fsm == FINAL), .result(roundOut));

   assign in_ready = fsm == IDLE;
   assign busy = fsm != IDLE;

   always_comb begin
      fsmNext = fsm;
      unique case (fsm)
         IDLE:    fsmNext = in_valid ? INIT : IDLE;
         INIT:    fsmNext = ROUND;
         ROUND:   fsmNext = rnd_q == 4'd1 ? FINAL : ROUND;
         FINAL:   fsmNext = DONE;
         DONE:    fsmNext = out_ready ? IDLE : DONE;
         default: fsmNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm <= IDLE;
         out_valid <= 1'b0;
         plaintext <= '0;
         rnd_q <= 4'd0;
         ct_q <= '0;
         key_q <= '0;
         state_q <= '0;
      end else begin
         fsm <= fsmNext;
         out_valid <= fsmNext == DONE;
         unique case (fsm)
            IDLE: if (in_valid) begin
               ct_q <= ciphertext;
               key_q <= key;
            end
            INIT: begin
               state_q <= ct_q ^ rk(roundKeys, 4'(AES_NR));
               rnd_q <= 4'd9;
            end
            ROUND: begin
               state_q <= roundOut;
               if (rnd_q != 4'd1) rnd_q <= rnd_q - 4'd1;
            end
            FINAL: plaintext <= roundOut;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes128_inv_cipher.sv
// tb_aes128_inv_cipher: directed FIPS-197 vectors plus handshake, stall and reset sequences.
module tb_aes128_inv_cipher;
   import aes_pkg::*;

   logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] ciphertext, key, plaintext;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   vec_t vecs [3];

   aes128_inv_cipher dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ciphertext(ciphertext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
      .plaintext(plaintext), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Accept one block, optionally pulse in_valid mid-round, optionally stall the output
   task automatic runBlock(input vec_t v, input int pulseAt, input int hold, input string tag);
      int n;
      in_valid = 1'b1;
      key = v.key;
      ciphertext = v.ct;
      out_ready = 1'b0;
      checkBit({tag, " in_ready before accept"}, in_ready, 1'b1);
      tick;
      key = ~v.key;
      ciphertext = ~v.ct;
      in_valid = 1'b0;
      checkBit({tag, " busy"}, busy, 1'b1);
      checkBit({tag, " in_ready busy"}, in_ready, 1'b0);
      n = 0;
      while (!out_valid && n < 40) begin
         in_valid = n == pulseAt;
         tick;
         n++;
      end
      in_valid = 1'b0;
      checkInt({tag, " latency"}, n, 11);
      check({tag, " plaintext"}, plaintext, v.pt);
      for (int i = 0; i < hold; i++) begin
         tick;
         check({tag, " stall plaintext"}, plaintext, v.pt);
         checkBit({tag, " stall in_ready"}, in_ready, 1'b0);
         checkBit({tag, " stall out_valid"}, out_valid, 1'b1);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      checkBit({tag, " out_valid after handshake"}, out_valid, 1'b0);
      checkBit({tag, " in_ready after handshake"}, in_ready, 1'b1);
   endtask

   initial begin
      int t, t1;
      bit sawValid;
      vecs[0] = '{key: FIPS_B_KEY, ct: FIPS_B_CT, pt: FIPS_B_PT};
      vecs[1] = '{key: FIPS_C1_KEY, ct: FIPS_C1_CT, pt: FIPS_C1_PT};
      vecs[2] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, pt: 128'h0};
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      key = '0;
      ciphertext = '0;
      tick;
      tick;
      rst_n = 1'b1;
      checkBit("reset in_ready", in_ready, 1'b1);
      checkBit("reset out_valid", out_valid, 1'b0);
      checkBit("reset busy", busy, 1'b0);
      check("reset plaintext", plaintext, 128'h0);

      for (int i = 0; i < 3; i++) runBlock(vecs[i], -1, 0, $sformatf("vec%0d", i));
      runBlock(vecs[0], -1, 20, "backpressure");
      runBlock(vecs[1], 4, 0, "ignored input");

      in_valid = 1'b1;
      out_ready = 1'b1;
      key = vecs[0].key;
      ciphertext = vecs[0].ct;
      tick;
      key = vecs[1].key;
      ciphertext = vecs[1].ct;
      t = 0;
      while (!out_valid && t < 40) begin
         tick;
         t++;
      end
      checkInt("b2b first latency", t, 11);
      check("b2b first plaintext", plaintext, vecs[0].pt);
      t1 = t;
      do begin
         tick;
         t++;
      end while (!out_valid && t < 80);
      checkInt("b2b spacing", t - t1, 13);
      check("b2b second plaintext", plaintext, vecs[1].pt);
      in_valid = 1'b0;
      tick;
      out_ready = 1'b0;
      checkBit("b2b idle", in_ready, 1'b1);

      in_valid = 1'b1;
      key = vecs[0].key;
      ciphertext = vecs[0].ct;
      tick;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      checkBit("midreset out_valid", out_valid, 1'b0);
      checkBit("midreset in_ready", in_ready, 1'b1);
      checkBit("midreset busy", busy, 1'b0);
      check("midreset plaintext", plaintext, 128'h0);
      sawValid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick;
         sawValid |= out_valid;
      end
      checkBit("midreset no stale out_valid", sawValid, 1'b0);
      runBlock(vecs[1], -1, 0, "after reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
